// File: rtl/sram_controller_pkg.sv
// Definitions shared by the SRAM controller, the MEM stage and the SRAM model.
package sram_controller_pkg;

    localparam int DATA_MEM_BASE = 1024;
    localparam int SRAM_WORD_W   = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

endpackage

// File: rtl/sram_controller.sv
// Two-half-access bridge from the 32-bit MEM stage to a 16-bit async SRAM.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transfer; accepts a store (priority) or a load
// RD_LO | low half read held on the pins, captured on its last cycle
// RD_HI | high half read held on the pins, captured on its last cycle
// WR_LO | low half driven; we_n low except the final recovery cycle
// WR_HI | high half driven; we_n low except the final recovery cycle
// DONE  | one-cycle completion, ready high so the pipeline advances
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int BASE_ADDR     = DATA_MEM_BASE,
    parameter int ACCESS_CYCLES = 2,
    parameter int SRAM_ADDR_W   = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    input  logic [SRAM_WORD_W-1:0] sram_dq_in,
    output logic [SRAM_WORD_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);

    localparam int   CNT_W        = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic HAS_RECOVERY = (ACCESS_CYCLES > 1);

    state_t                 state, state_next;
    logic [CNT_W-1:0]       cnt;
    logic                   last;
    logic                   in_access;
    logic [31:0]            offset;
    logic [SRAM_ADDR_W-2:0] word_q;
    logic [31:0]            wdata_q;
    logic                   unused_offset_bits;

    // Byte offset from the SRAM window base; wraps modulo 2^32 by design.
    assign offset             = address - 32'(BASE_ADDR);
    assign unused_offset_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

    assign last      = (cnt == CNT_W'(ACCESS_CYCLES - 1));
    assign in_access = (state == RD_LO) || (state == RD_HI) ||
                       (state == WR_LO) || (state == WR_HI);

    // State register and per-state wait counter, restarted on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state || !in_access)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
        end
    end

    // Request latches on acceptance and load-data capture at the end of each half.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q    <= '0;
            wdata_q   <= '0;
            read_data <= '0;
        end else begin
            if (state == IDLE && (mem_w_en || mem_r_en))
                word_q <= offset[SRAM_ADDR_W:2];
            if (state == IDLE && mem_w_en)
                wdata_q <= write_data;
            if (state == RD_LO && last)
                read_data[15:0] <= sram_dq_in;
            if (state == RD_HI && last)
                read_data[31:16] <= sram_dq_in;
        end
    end

    // Next-state decode and SRAM pin drive.
    always_comb begin
        state_next  = state;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state)
            IDLE: begin
                ready = !(mem_r_en || mem_w_en);
                if (mem_w_en)
                    state_next = WR_LO;
                else if (mem_r_en)
                    state_next = RD_LO;
            end
            RD_LO: begin
                sram_addr = {word_q, 1'b0};
                if (last)
                    state_next = RD_HI;
            end
            RD_HI: begin
                sram_addr = {word_q, 1'b1};
                if (last)
                    state_next = DONE;
            end
            WR_LO: begin
                sram_addr   = {word_q, 1'b0};
                sram_dq_out = wdata_q[15:0];
                sram_dq_oe  = 1'b1;
                sram_we_n   = last & HAS_RECOVERY;
                if (last)
                    state_next = WR_HI;
            end
            WR_HI: begin
                sram_addr   = {word_q, 1'b1};
                sram_dq_out = wdata_q[31:16];
                sram_dq_oe  = 1'b1;
                sram_we_n   = last & HAS_RECOVERY;
                if (last)
                    state_next = DONE;
            end
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural 16-bit SRAM.
module tb_sram_controller;
    import sram_controller_pkg::*;

    logic        clk;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] write_data;

    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_in;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic        sram_we_n;

    logic [31:0] read_data1, read_data4;
    logic        ready1, ready4;
    logic [17:0] sram_addr1, sram_addr4;
    logic [15:0] sram_dq_out1, sram_dq_out4;
    logic        sram_dq_oe1, sram_dq_oe4;
    logic        sram_we_n1, sram_we_n4;
    logic [15:0] dq_zero;

    logic [15:0] mem0 [0:262143];

    int checks;
    int failures;

    sram_controller #(.BASE_ADDR(DATA_MEM_BASE), .ACCESS_CYCLES(2), .SRAM_ADDR_W(18)) u_dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    sram_controller #(.BASE_ADDR(DATA_MEM_BASE), .ACCESS_CYCLES(1), .SRAM_ADDR_W(18)) u_dut1 (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .address(address), .write_data(write_data), .read_data(read_data1), .ready(ready1),
        .sram_addr(sram_addr1), .sram_dq_in(dq_zero), .sram_dq_out(sram_dq_out1),
        .sram_dq_oe(sram_dq_oe1), .sram_we_n(sram_we_n1)
    );

    sram_controller #(.BASE_ADDR(DATA_MEM_BASE), .ACCESS_CYCLES(4), .SRAM_ADDR_W(18)) u_dut4 (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .address(address), .write_data(write_data), .read_data(read_data4), .ready(ready4),
        .sram_addr(sram_addr4), .sram_dq_in(dq_zero), .sram_dq_out(sram_dq_out4),
        .sram_dq_oe(sram_dq_oe4), .sram_we_n(sram_we_n4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dq_zero    = 16'h0000;
    assign sram_dq_in = mem0[sram_addr];

    // SRAM model: a write lands at the clock edge that ends a we_n-low cycle;
    // a strobe cut short by system reset does not land.
    always @(posedge clk) begin
        if (!rst && sram_dq_oe && !sram_we_n)
            mem0[sram_addr] <= sram_dq_out;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // One request presented in cycle 0 and held until ready, as the frozen pipeline would.
    task automatic do_txn(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output int we_lo);
        @(negedge clk);
        mem_w_en   = w;
        mem_r_en   = r;
        address    = a;
        write_data = d;
        lat        = -1;
        we_lo      = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!sram_we_n) we_lo++;
            if (ready) begin
                lat = k;
                break;
            end
        end
        mem_w_en = 1'b0;
        mem_r_en = 1'b0;
    endtask

    typedef struct packed {
        logic        w;
        logic        r;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [17:0] lo_idx;
        logic [15:0] lo_val;
        logic [17:0] hi_idx;
        logic [15:0] hi_val;
        logic [3:0]  exp_we;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int lat, we_lo, bad;
        int lat0, lat1, lat4;
        int lo0, hi0, lo1, hi1, lo4, hi4;
        int t1, t2, b2b_we;
        logic [31:0] rd1, rd2;

        checks   = 0;
        failures = 0;

        vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h00000000, 18'd0, 16'hBEEF, 18'd1, 16'hDEAD, 4'd2};
        vecs[1] = '{1'b0, 1'b1, 32'd1024, 32'h00000000, 32'hDEADBEEF, 18'd0, 16'hBEEF, 18'd1, 16'hDEAD, 4'd0};
        vecs[2] = '{1'b1, 1'b0, 32'd1036, 32'h12345678, 32'hDEADBEEF, 18'd6, 16'h5678, 18'd7, 16'h1234, 4'd2};
        vecs[3] = '{1'b0, 1'b1, 32'd1038, 32'h00000000, 32'h12345678, 18'd6, 16'h5678, 18'd7, 16'h1234, 4'd0};
        vecs[4] = '{1'b1, 1'b0, 32'd1039, 32'hCAFEF00D, 32'h12345678, 18'd6, 16'hF00D, 18'd7, 16'hCAFE, 4'd2};
        vecs[5] = '{1'b0, 1'b1, 32'd1036, 32'h00000000, 32'hCAFEF00D, 18'd6, 16'hF00D, 18'd7, 16'hCAFE, 4'd0};
        vecs[6] = '{1'b1, 1'b0, 32'd1020, 32'hA5A55A5A, 32'hCAFEF00D, 18'h3FFFE, 16'h5A5A, 18'h3FFFF, 16'hA5A5, 4'd2};
        vecs[7] = '{1'b0, 1'b1, 32'd1020, 32'h00000000, 32'hA5A55A5A, 18'h3FFFE, 16'h5A5A, 18'h3FFFF, 16'hA5A5, 4'd0};
        vecs[8] = '{1'b1, 1'b1, 32'd1024, 32'h0BADF00D, 32'hA5A55A5A, 18'd0, 16'hF00D, 18'd1, 16'h0BAD, 4'd2};

        rst        = 1'b1;
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b0;
        address    = 32'd0;
        write_data = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_ready", 32'(ready), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_out", 32'(sram_dq_out), 32'd0);
        check("rst_read_data", read_data, 32'd0);

        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!ready || !sram_we_n) bad++;
        end
        check("idle_10_cycles", 32'(bad), 32'd0);

        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i].w, vecs[i].r, vecs[i].addr, vecs[i].wdata, lat, we_lo);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
            check($sformatf("vec%0d_read_data", i), read_data, vecs[i].exp_rd);
            check($sformatf("vec%0d_we_low_cycles", i), 32'(we_lo), 32'(vecs[i].exp_we));
            check($sformatf("vec%0d_sram_lo", i), 32'(mem0[vecs[i].lo_idx]), 32'(vecs[i].lo_val));
            check($sformatf("vec%0d_sram_hi", i), 32'(mem0[vecs[i].hi_idx]), 32'(vecs[i].hi_val));
        end

        // Reset in the first cycle of WR_HI abandons the store.
        @(negedge clk);
        mem_w_en   = 1'b1;
        address    = 32'd1024;
        write_data = 32'h77776666;
        repeat (3) @(negedge clk);
        check("midwr_we_n_low", 32'(sram_we_n), 32'd0);
        rst      = 1'b1;
        mem_w_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("midwr_ready", 32'(ready), 32'd1);
        check("midwr_we_n", 32'(sram_we_n), 32'd1);
        check("midwr_oe", 32'(sram_dq_oe), 32'd0);
        check("midwr_read_data", read_data, 32'd0);
        check("midwr_sram_word0", 32'(mem0[0]), 32'h6666);
        check("midwr_sram_word1", 32'(mem0[1]), 32'h0BAD);

        // Latency sweep across ACCESS_CYCLES = 2, 1, 4 with a one-cycle store request.
        lat0 = -1; lat1 = -1; lat4 = -1;
        lo0 = 0; hi0 = 0; lo1 = 0; hi1 = 0; lo4 = 0; hi4 = 0;
        @(negedge clk);
        mem_w_en   = 1'b1;
        address    = 32'd1024;
        write_data = 32'h55AA33CC;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            mem_w_en = 1'b0;
            if (ready  && lat0 < 0) lat0 = k;
            if (ready1 && lat1 < 0) lat1 = k;
            if (ready4 && lat4 < 0) lat4 = k;
            if (!sram_we_n)  begin if (sram_addr[0])  hi0++; else lo0++; end
            if (!sram_we_n1) begin if (sram_addr1[0]) hi1++; else lo1++; end
            if (!sram_we_n4) begin if (sram_addr4[0]) hi4++; else lo4++; end
        end
        check("sweep_ac2_latency", 32'(lat0), 32'd5);
        check("sweep_ac1_latency", 32'(lat1), 32'd3);
        check("sweep_ac4_latency", 32'(lat4), 32'd9);
        check("sweep_ac2_we_lo", 32'(lo0), 32'd1);
        check("sweep_ac2_we_hi", 32'(hi0), 32'd1);
        check("sweep_ac1_we_lo", 32'(lo1), 32'd1);
        check("sweep_ac1_we_hi", 32'(hi1), 32'd1);
        check("sweep_ac4_we_lo", 32'(lo4), 32'd3);
        check("sweep_ac4_we_hi", 32'(hi4), 32'd3);
        check("sweep_sram_word0", 32'(mem0[0]), 32'h33CC);
        check("sweep_sram_word1", 32'(mem0[1]), 32'h55AA);

        // Back-to-back loads with inputs disturbed mid-transfer.
        do_txn(1'b1, 1'b0, 32'd1028, 32'h13572468, lat, we_lo);
        check("b2b_setup_latency", 32'(lat), 32'd5);
        @(negedge clk);
        mem_r_en = 1'b1;
        address  = 32'd1024;
        t1 = -1; t2 = -1; b2b_we = 0;
        rd1 = '0; rd2 = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!sram_we_n) b2b_we++;
            if (k == 2) begin
                address    = 32'd2000;
                write_data = 32'hFFFFFFFF;
            end
            if (ready) begin
                if (t1 < 0) begin
                    t1       = k;
                    rd1      = read_data;
                    address  = 32'd1028;
                    mem_w_en = 1'b0;
                end else begin
                    t2  = k;
                    rd2 = read_data;
                    break;
                end
            end
            if (t1 >= 0 && k == t1 + 3) begin
                address  = 32'd1100;
                mem_w_en = 1'b1;
            end
        end
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        check("b2b_first_done", 32'(t1), 32'd5);
        check("b2b_spacing", 32'(t2 - t1), 32'd6);
        check("b2b_first_data", rd1, 32'h55AA33CC);
        check("b2b_second_data", rd2, 32'h13572468);
        check("b2b_no_write", 32'(b2b_we), 32'd0);
        @(negedge clk);
        check("b2b_final_ready", 32'(ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
